sprite_layer_renderer: RTL and testbench

- Parametrised successor to the single full-screen sprite example.
- Draws one animated sprite at a programmable screen position, with integer power-of-two scaling, horizontal flip, a transparent colour index and background pass-through.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour mux.
- Sprite ROM and palette are external; the block drives the ROM address, then aligns all side-band data to the ROM read latency.

---
 rtl/sprite_layer_renderer.sv | 158 +++++++++++++++
 tb/tb_sprite_layer_renderer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_renderer.sv
// Single animated sprite layer between the VGA timing generator and the colour mux.
// Optional scaled bounding-box outline (debug aid) is enabled by defining SPRITE_BBOX_DBG_EN.
module sprite_layer_renderer #(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned V_ACTIVE   = 480,
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned AW = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic [9:0]       spr_x,
  input  logic [9:0]       spr_y,
  input  logic [1:0]       scale,
  input  logic             flip_h,
  input  logic             anim_en,
  input  logic [FW-1:0]    frame_sel,
  input  logic [11:0]      bg_rgb,
  output logic [AW-1:0]    rom_addr,
  input  logic [IDX_W-1:0] rom_q,
  output logic [IDX_W-1:0] pal_idx,
  input  logic [11:0]      pal_rgb,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             sprite_on
);

  localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic signed [10:0] dx, dy;
  logic [9:0]         lx_raw, ly_raw, lx;
  logic               hit;
  logic [FW-1:0]      cur_frame, frame_q, frame_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tick_cond, tick_cond_q, tick;

  logic [ROM_LAT-1:0] hit_dq, blank_dq;
  logic [11:0]        bg_dq [ROM_LAT];
  logic [11:0]        rgb_d;
  logic               on_d;

  // Stage 0: hit test and texel addressing
  assign dx     = $signed({1'b0, DrawX}) - $signed({1'b0, spr_x});
  assign dy     = $signed({1'b0, DrawY}) - $signed({1'b0, spr_y});
  assign lx_raw = dx[9:0] >> scale;
  assign ly_raw = dy[9:0] >> scale;
  assign hit    = !dx[10] && !dy[10] && (32'(lx_raw) < SPR_W) && (32'(ly_raw) < SPR_H);
  assign lx     = flip_h ? (10'(SPR_W - 1) - lx_raw) : lx_raw;

  assign cur_frame = anim_en ? frame_q : frame_sel;
  assign rom_addr  = hit ? AW'(AW'(cur_frame) * AW'(SPR_W * SPR_H) + AW'(ly_raw) * AW'(SPR_W)
                              + AW'(lx)) : '0;
  assign pal_idx   = rom_q;

`ifdef SPRITE_BBOX_DBG_EN
  logic             box;
  logic [ROM_LAT-1:0] box_dq;
  assign box = hit && (dx == 11'sd0 || dy == 11'sd0 ||
                       32'(dx[9:0]) == (SPR_W << scale) - 1 ||
                       32'(dy[9:0]) == (SPR_H << scale) - 1);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      box_dq <= '0;
    end else begin
      box_dq[0] <= box;
      for (int i = 1; i < int'(ROM_LAT); i++) box_dq[i] <= box_dq[i-1];
    end
  end
`endif

  // Side-band delay lines align hit/blank/background with rom_q
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hit_dq   <= '0;
      blank_dq <= '0;
      for (int i = 0; i < int'(ROM_LAT); i++) bg_dq[i] <= '0;
    end else begin
      hit_dq[0]   <= hit;
      blank_dq[0] <= blank;
      bg_dq[0]    <= bg_rgb;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        hit_dq[i]   <= hit_dq[i-1];
        blank_dq[i] <= blank_dq[i-1];
        bg_dq[i]    <= bg_dq[i-1];
      end
    end
  end

  always_comb begin
    rgb_d = bg_dq[ROM_LAT-1];
    on_d  = 1'b0;
    if (!blank_dq[ROM_LAT-1]) begin
      rgb_d = '0;
`ifdef SPRITE_BBOX_DBG_EN
    end else if (box_dq[ROM_LAT-1]) begin
      rgb_d = 12'hF0F;
      on_d  = 1'b1;
`endif
    end else if (hit_dq[ROM_LAT-1] && rom_q != IDX_W'(TRANSP_IDX)) begin
      rgb_d = pal_rgb;
      on_d  = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      sprite_on <= 1'b0;
    end else begin
      red       <= rgb_d[11:8];
      green     <= rgb_d[7:4];
      blue      <= rgb_d[3:0];
      sprite_on <= on_d;
    end
  end

  // One tick per video frame, however long the beam dwells at (0, V_ACTIVE)
  assign tick_cond = (DrawY == 10'(V_ACTIVE)) && (DrawX == '0);
  assign tick      = tick_cond && !tick_cond_q;

  always_comb begin
    frame_d = frame_q;
    div_d   = div_q;
    if (tick && anim_en) begin
      if (div_q == DW'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      tick_cond_q <= 1'b0;
      frame_q     <= '0;
      div_q       <= '0;
    end else begin
      tick_cond_q <= tick_cond;
      frame_q     <= frame_d;
      div_q       <= div_d;
    end
  end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Self-checking bench for sprite_layer_renderer: directed cases plus randomized pixels
// compared against a texel-level reference model.
module tb_sprite_layer_renderer;
  localparam int SPR_W = 32, SPR_H = 32, FRAMES = 4, IDX_W = 4, ROM_LAT = 1;
  localparam int TRANSP_IDX = 0, ANIM_DIV = 2, V_ACTIVE = 480;
  localparam int AW = 12, FW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [9:0]       DrawX, DrawY, spr_x, spr_y;
  logic             blank, flip_h, anim_en;
  logic [1:0]       scale;
  logic [FW-1:0]    frame_sel;
  logic [11:0]      bg_rgb, pal_rgb;
  logic [AW-1:0]    rom_addr;
  logic [IDX_W-1:0] rom_q, pal_idx;
  logic [3:0]       red, green, blue;
  logic             sprite_on;

  sprite_layer_renderer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W), .ROM_LAT(ROM_LAT),
    .TRANSP_IDX(TRANSP_IDX), .ANIM_DIV(ANIM_DIV), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .spr_x(spr_x), .spr_y(spr_y), .scale(scale), .flip_h(flip_h), .anim_en(anim_en),
    .frame_sel(frame_sel), .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .red(red), .green(green), .blue(blue),
    .sprite_on(sprite_on)
  );

  always #5 clk = ~clk;

  // External ROM with ROM_LAT cycles of latency and a combinational palette
  logic [IDX_W-1:0] rom [FRAMES*SPR_W*SPR_H];
  logic [11:0]      pal [16];
  logic [IDX_W-1:0] rq  [ROM_LAT];
  always @(posedge clk) begin
    rq[0] <= rom[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_q   = rq[ROM_LAT-1];
  assign pal_rgb = pal[pal_idx];

  int errors = 0;
  int checks = 0;
  int ticks  = 0;           // enabled frame ticks since reset
  logic [12:0] expq[$];     // {sprite_on, rgb} expected, in issue order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [9:0] x, input logic [9:0] y, input logic bl,
                                output logic [12:0] e, output logic [AW-1:0] ea);
    int dx, dy, lx, ly, fr, a;
    bit hit, outline;
    dx  = int'(x) - int'(spr_x);
    dy  = int'(y) - int'(spr_y);
    fr  = anim_en ? (ticks / ANIM_DIV) % FRAMES : int'(frame_sel);
    hit = dx >= 0 && dy >= 0 && (dx >> scale) < SPR_W && (dy >> scale) < SPR_H;
    lx  = dx >> scale;
    if (flip_h) lx = SPR_W - 1 - lx;
    ly  = dy >> scale;
    a   = fr * SPR_W * SPR_H + ly * SPR_W + lx;
    ea  = hit ? AW'(a) : '0;
    outline = hit && (dx == 0 || dy == 0 || dx == (SPR_W << scale) - 1 ||
                      dy == (SPR_H << scale) - 1);
    e = {1'b0, bg_rgb};
    if (!bl) e = '0;
`ifdef SPRITE_BBOX_DBG_EN
    else if (outline) e = {1'b1, 12'hF0F};
`endif
    else if (hit && int'(rom[a]) != TRANSP_IDX) e = {1'b1, pal[rom[a]]};
  endfunction

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic bl);
    logic [12:0]   e;
    logic [AW-1:0] ea;
    DrawX  = x;
    DrawY  = y;
    blank  = bl;
    bg_rgb = 12'($urandom);
    #1;
    model(x, y, bl, e, ea);
    if (reset_n) begin
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      chk("reset_out", 32'({sprite_on, red, green, blue}), 32'd0);
      expq.delete();
      for (int i = 0; i < ROM_LAT; i++) expq.push_back(13'd0);  // flushed pipeline
    end else if (expq.size() == ROM_LAT + 1) begin
      chk("pixel_out", 32'({sprite_on, red, green, blue}), 32'(expq.pop_front()));
    end
  endtask

  // Beam dwells several cycles at the tick position, then moves on
  task automatic frame_tick();
    step(10'd0, 10'(V_ACTIVE), 1'b0);
    if (anim_en) ticks++;
    for (int i = 0; i < 3; i++) step(10'd0, 10'(V_ACTIVE), 1'b0);
    step(10'd1, 10'(V_ACTIVE), 1'b0);
  endtask

  int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    for (int i = 0; i < FRAMES*SPR_W*SPR_H; i++) rom[i] = IDX_W'($urandom);
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
    rom[2048] = 4'd5;
    rom[2*1024 + 1*32 + 1] = 4'(TRANSP_IDX);
    reset_n = 1'b0; spr_x = 10'd100; spr_y = 10'd50; scale = 2'd0; flip_h = 1'b0;
    anim_en = 1'b0; frame_sel = 2'd2; DrawX = '0; DrawY = '0; blank = 1'b0; bg_rgb = '0;

    // Power-on reset
    for (int i = 0; i < 3; i++) step(10'd100, 10'd50, 1'b1);
    reset_n = 1'b1;
    ticks   = 0;

    // Basic hit, frame_sel addressing, right edge and outside pixels
    step(10'd100, 10'd50, 1'b1);
    step(10'd131, 10'd81, 1'b1);
    step(10'd132, 10'd50, 1'b1);
    step(10'd99, 10'd50, 1'b1);
    step(10'd100, 10'd49, 1'b1);
    step(10'd100, 10'd50, 1'b1);

    // Transparent texel and blanked sprite pixels
    step(10'd101, 10'd51, 1'b1);
    step(10'd105, 10'd55, 1'b0);
    step(10'd110, 10'd60, 1'b1);

    // Reset held mid-line with the sprite under the beam
    for (int x = 102; x < 110; x++) step(10'(x), 10'd52, 1'b1);
    reset_n = 1'b0;
    for (int x = 110; x < 113; x++) step(10'(x), 10'd52, 1'b1);
    reset_n = 1'b1;
    ticks   = 0;
    for (int x = 113; x < 120; x++) step(10'(x), 10'd52, 1'b1);

    // Scale 4 with horizontal flip at the left screen edge
    spr_x = 10'd0; spr_y = 10'd0; scale = 2'd2; flip_h = 1'b1;
    for (int x = 0; x < 4; x++) step(10'(x), 10'd5, 1'b1);
    for (int x = 124; x < 130; x++) step(10'(x), 10'd127, 1'b1);
    step(10'd0, 10'd128, 1'b1);

    // Auto-animation over ten ticks
    spr_x = 10'd100; spr_y = 10'd50; scale = 2'd0; flip_h = 1'b0; anim_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      DrawX = 10'd100; DrawY = 10'd50; #1;
      chk("anim_frame", 32'(rom_addr), 32'(seq[k] * 1024));
      step(10'd100, 10'd50, 1'b1);
      frame_tick();
    end
    anim_en = 1'b0; frame_sel = 2'd3;
    frame_tick();
    step(10'd100, 10'd50, 1'b1);
    anim_en = 1'b1;
    step(10'd100, 10'd50, 1'b1);
    frame_tick();
    step(10'd100, 10'd50, 1'b1);

    // Clipping at the right screen edge, no wrap to column 0
    anim_en = 1'b0; frame_sel = 2'd1; spr_x = 10'd620; spr_y = 10'd100;
    for (int x = 615; x < 640; x++) step(10'(x), 10'd110, 1'b1);
    for (int x = 0; x < 4; x++) step(10'(x), 10'd110, 1'b1);

    // Randomized positions, scales, flips and frames
    for (int n = 0; n < 600; n++) begin
      logic [9:0] x, y;
      if (n % 30 == 0) begin
        spr_x     = 10'($urandom_range(0, 639));
        spr_y     = 10'($urandom_range(0, 479));
        scale     = 2'($urandom);
        flip_h    = 1'($urandom);
        anim_en   = 1'($urandom);
        frame_sel = 2'($urandom);
        if (anim_en && $urandom_range(0, 1) == 1) frame_tick();
      end
      x = 10'(int'(spr_x) + int'($urandom_range(0, (SPR_W << scale) + 8)) - 4);
      y = 10'(int'(spr_y) + int'($urandom_range(0, (SPR_H << scale) + 8)) - 4);
      if (y == 10'(V_ACTIVE) && x == 10'd0) x = 10'd1;
      step(x, y, ($urandom_range(0, 9) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
